// File: rtl/seq_pattern_gen_pkg.sv
// seq_pattern_gen_pkg: shared FSM state encoding and default widths for the pattern generator
package seq_pattern_gen_pkg;
    localparam int PAT_W_DEF = 8;
    localparam int LEN_W_DEF = 4;
    localparam int REP_W_DEF = 8;
    localparam int GAP_W_DEF = 4;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;
endpackage

// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: request (start/pattern/pat_len/reps/gap) and serial output (x/x_vld/busy/done) bundle
//   master: drives the request, observes the stream; slave: the generator itself
interface seq_pattern_gen_if
    import seq_pattern_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int REP_W = REP_W_DEF,
    parameter int GAP_W = GAP_W_DEF
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic [REP_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             x;
    logic             x_vld;
    logic             busy;
    logic             done;
    modport master (output start, pattern, pat_len, reps, gap, input x, x_vld, busy, done);
    modport slave  (input start, pattern, pat_len, reps, gap, output x, x_vld, busy, done);
endinterface

// File: rtl/seq_pattern_gen_shreg.sv
// seq_pattern_gen_shreg: W-bit parallel-load left-shift register, async active-low clear
//   clk, rst_n; load (d -> q, wins over shift); shift (q <<= 1, zero fill); q current contents
module seq_pattern_gen_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] sr_q, sr_d;
    always_comb sr_d = load ? d : shift ? {sr_q[W-2:0], 1'b0} : sr_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
    assign q = sr_q;
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: loads an N-bit pattern on start and sends it MSB-first on x, repeated with idle gaps
//   clk, rst_n (async active-low); bus.slave: start/pattern/pat_len/reps/gap in, x/x_vld/busy/done out
module seq_pattern_gen
    import seq_pattern_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int REP_W = REP_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_pattern_gen_if.slave bus
);
    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_c, len_q, len_d, bit_q, bit_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
    logic [PAT_W-1:0] pat_q, pat_d, ld_data, sr;
    logic             x_vld_q, x_vld_d, busy_q, busy_d, done_q, done_d;
    logic             load, shift;

    assign len_c = (bus.pat_len == '0 || bus.pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.pat_len;

    // The pattern is stored left-aligned, so the current bit is always the register MSB and the
    // zero fill from shifting leaves x=0 once a copy has been fully sent.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        pat_d   = pat_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d = S_SEND;
                len_d   = len_c;
                bit_d   = len_c - 1'b1;
                rep_d   = (bus.reps == '0) ? '0 : bus.reps - 1'b1;
                gap_d   = bus.gap;
                pat_d   = bus.pattern << (LEN_W'(PAT_W) - len_c);
                load    = 1'b1;
            end
            S_SEND: if (bit_q != '0) begin
                bit_d = bit_q - 1'b1;
                shift = 1'b1;
            end else if (rep_q == '0) begin
                state_d = S_FIN;
                shift   = 1'b1;
            end else if (gap_q != '0) begin
                state_d = S_GAP;
                rep_d   = rep_q - 1'b1;
                gcnt_d  = gap_q - 1'b1;
                shift   = 1'b1;
            end else begin
                rep_d = rep_q - 1'b1;
                bit_d = len_q - 1'b1;
                load  = 1'b1;
            end
            S_GAP: if (gcnt_q != '0) begin
                gcnt_d = gcnt_q - 1'b1;
            end else begin
                state_d = S_SEND;
                bit_d   = len_q - 1'b1;
                load    = 1'b1;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ld_data = (state_q == S_IDLE) ? pat_d : pat_q;
        x_vld_d = state_d == S_SEND;
        busy_d  = state_d != S_IDLE;
        done_d  = state_d == S_FIN;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            pat_q   <= '0;
            x_vld_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            pat_q   <= pat_d;
            x_vld_q <= x_vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end

    seq_pattern_gen_shreg #(.W(PAT_W)) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .d     (ld_data),
        .q     (sr)
    );

    assign bus.x     = sr[PAT_W-1];
    assign bus.x_vld = x_vld_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: vector table, hand corner sequences and random traffic against a cycle-stream model
module tb_seq_pattern_gen;
    import seq_pattern_gen_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_pattern_gen_if bus ();
    seq_pattern_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Reference: on an accepted start, the whole expected output sequence is expanded into a
    // queue of per-cycle {x, x_vld, busy, done} records, then replayed one per clock.
    logic [3:0] q[$];
    logic [3:0] exp_cur;

    function automatic void expand(input logic [7:0] p, input logic [3:0] l_in,
                                   input logic [7:0] r_in, input logic [3:0] g);
        int l = (l_in == 0 || l_in > 8) ? 8 : int'(l_in);
        int r = (r_in == 0) ? 1 : int'(r_in);
        for (int c = 0; c < r; c++) begin
            for (int i = l - 1; i >= 0; i--) q.push_back({p[i], 3'b110});
            if (c < r - 1) for (int k = 0; k < int'(g); k++) q.push_back(4'b0010);
        end
        q.push_back(4'b0011);
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            q.delete();
            exp_cur <= 4'b0;
        end else begin
            if (!exp_cur[1] && bus.start) expand(bus.pattern, bus.pat_len, bus.reps, bus.gap);
            if (q.size() > 0) exp_cur <= q.pop_front();
            else exp_cur <= 4'b0;
        end

    always @(negedge clk) begin
        checks++;
        if ({bus.x, bus.x_vld, bus.busy, bus.done} !== exp_cur) begin
            errors++;
            $display("FAIL cycle_model t=%0t got {x,vld,busy,done}=%b expected=%b", $time,
                     {bus.x, bus.x_vld, bus.busy, bus.done}, exp_cur);
        end
    end

    typedef struct {
        string       name;
        logic [7:0]  pattern;
        logic [3:0]  len;
        logic [7:0]  reps;
        logic [3:0]  gap;
        bit          spam;
        logic [31:0] exp_stream;
        int          exp_nbits;
        int          exp_busy;
    } vec_t;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] s = '0;
        int nb = 0, nbusy = 0, nd = 0, cyc = 0;
        @(negedge clk);
        bus.pattern = v.pattern;
        bus.pat_len = v.len;
        bus.reps    = v.reps;
        bus.gap     = v.gap;
        bus.start   = 1'b1;
        @(negedge clk);
        while (cyc < 2000) begin
            if (bus.x_vld) begin
                s = {s[30:0], bus.x};
                nb++;
            end
            if (bus.busy) nbusy++;
            if (bus.done) nd++;
            if (!bus.busy) break;
            bus.start   = v.spam & ~bus.done;
            bus.pattern = 8'($urandom);
            bus.pat_len = 4'($urandom);
            bus.reps    = 8'($urandom);
            bus.gap     = 4'($urandom);
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({v.name, "_timeout"}, longint'(cyc >= 2000), 0);
        check({v.name, "_stream"}, s, v.exp_stream);
        check({v.name, "_nbits"}, nb, v.exp_nbits);
        check({v.name, "_busy"}, nbusy, v.exp_busy);
        check({v.name, "_done"}, nd, 1);
    endtask

    vec_t tab[10];

    initial begin
        tab[0] = '{"t2_101",      8'h05, 4'd3,  8'd1,   4'd0,  1'b0, 32'h5,        3,   4};
        tab[1] = '{"t3_101x3",    8'h05, 4'd3,  8'd3,   4'd0,  1'b0, 32'h16D,      9,   10};
        tab[2] = '{"t4_b4_gap2",  8'hB4, 4'd8,  8'd2,   4'd2,  1'b0, 32'hB4B4,     16,  19};
        tab[3] = '{"t5_restart",  8'hB4, 4'd8,  8'd2,   4'd2,  1'b1, 32'hB4B4,     16,  19};
        tab[4] = '{"t6_len0rep0", 8'hA5, 4'd0,  8'd0,   4'd0,  1'b0, 32'hA5,       8,   9};
        tab[5] = '{"t6_len1rep4", 8'h01, 4'd1,  8'd4,   4'd0,  1'b0, 32'hF,        4,   5};
        tab[6] = '{"len_over",    8'h3C, 4'd12, 8'd1,   4'd1,  1'b0, 32'h3C,       8,   9};
        tab[7] = '{"gap_max",     8'h02, 4'd2,  8'd2,   4'd15, 1'b0, 32'hA,        4,   20};
        tab[8] = '{"reps_max",    8'h01, 4'd1,  8'd255, 4'd0,  1'b0, 32'hFFFFFFFF, 255, 256};
        tab[9] = '{"upper_bits",  8'hF2, 4'd3,  8'd1,   4'd0,  1'b0, 32'h2,        3,   4};

        bus.start = 1'b0;
        bus.pattern = '0;
        bus.pat_len = '0;
        bus.reps = '0;
        bus.gap = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.x, bus.x_vld, bus.busy, bus.done}, 0);
        rst_n = 1'b1;

        foreach (tab[i]) run_vec(tab[i]);

        // Reset in the middle of a copy: outputs drop without waiting for a clock edge.
        @(negedge clk);
        bus.pattern = 8'hFF;
        bus.pat_len = 4'd8;
        bus.reps = 8'd3;
        bus.gap = 4'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("t1_pre_reset", {bus.x, bus.x_vld, bus.busy, bus.done}, 4'b1110);
        #2 rst_n = 1'b0;
        #1 check("t1_async_reset", {bus.x, bus.x_vld, bus.busy, bus.done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(tab[0]);

        // Random traffic: the cycle model checks every clock.
        repeat (3000) begin
            @(negedge clk);
            bus.start   = ($urandom_range(0, 3) == 0);
            bus.pattern = 8'($urandom);
            bus.pat_len = 4'($urandom);
            bus.reps    = 8'($urandom_range(0, 5));
            bus.gap     = 4'($urandom_range(0, 3));
        end
        bus.start = 1'b0;
        repeat (200) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
